// File: rtl/gpio_in_conditioner.sv
// Purpose: per-channel GPIO input conditioning: sync, polarity fix, debounce, edge detect, sticky flags, irq.
// Latency: val_o follows a stable pin SyncStages+DebounceCycles clocks after capture (SyncStages+1 in bypass).
// Backpressure: none; free-running per-cycle pipeline, edges are held in sticky flags until cleared.
module gpio_in_conditioner #(
  parameter int              NumCh          = 16,
  parameter int              SyncStages     = 2,
  parameter int              DebounceCycles = 40000,
  parameter logic [NumCh-1:0] InvertMask    = '1,
  parameter int              CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [NumCh-1:0] pins_i,
  input  logic [NumCh-1:0] debounce_en_i,
  input  logic [NumCh-1:0] rise_en_i,
  input  logic [NumCh-1:0] fall_en_i,
  input  logic [NumCh-1:0] clr_i,
  input  logic [NumCh-1:0] irq_en_i,
  output logic [NumCh-1:0] val_o,
  output logic [NumCh-1:0] rise_o,
  output logic [NumCh-1:0] fall_o,
  output logic [NumCh-1:0] sticky_o,
  output logic             irq_o
);

  // Terminal count: reaching it on a mismatch cycle means DebounceCycles
  // consecutive mismatches have been seen, so the new level is accepted.
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [NumCh-1:0]    r_sync [SyncStages];
  logic [CntWidth-1:0] r_cnt  [NumCh];
  logic [CntWidth-1:0] w_cnt_nxt [NumCh];
  logic [NumCh-1:0]    r_val;
  logic [NumCh-1:0]    r_rise;
  logic [NumCh-1:0]    r_fall;
  logic [NumCh-1:0]    r_sticky;
  logic [NumCh-1:0]    w_s;
  logic [NumCh-1:0]    w_val_nxt;
  logic [NumCh-1:0]    w_sticky_nxt;

  // Synchroniser chain; resetting to InvertMask makes the corrected level 0.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < SyncStages; i++) begin
        r_sync[i] <= InvertMask;
      end
    end else begin
      r_sync[0] <= pins_i;
      for (int i = 1; i < SyncStages; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Polarity-corrected synchronised level; the only input to the debouncer.
  assign w_s = r_sync[SyncStages-1] ^ InvertMask;

  // Debounce decision per channel: a matching cycle restarts the count, the
  // DebounceCycles-th consecutive mismatch accepts the new level.
  always_comb begin
    w_val_nxt = r_val;
    for (int i = 0; i < NumCh; i++) begin
      w_cnt_nxt[i] = '0;
      if (!debounce_en_i[i]) begin
        w_val_nxt[i] = w_s[i];
      end else if (w_s[i] != r_val[i]) begin
        if (r_cnt[i] == CntLast) begin
          w_val_nxt[i] = w_s[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CntWidth'(1);
        end
      end
    end
  end

  // Set beats clear so an edge landing on the clear cycle is never lost.
  assign w_sticky_nxt = (r_sticky & ~clr_i) | (r_rise & rise_en_i) | (r_fall & fall_en_i);

  // Debounce counters, one per channel with no sharing.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < NumCh; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Level, edge pulses and sticky flags; pulses coincide with the first
  // cycle the new level is visible.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_val    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_sticky <= '0;
    end else begin
      r_val    <= w_val_nxt;
      r_rise   <= w_val_nxt & ~r_val;
      r_fall   <= ~w_val_nxt & r_val;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign val_o    = r_val;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;
  assign sticky_o = r_sticky;
  // Combinational so masking takes effect immediately without touching sticky.
  assign irq_o    = |(r_sticky & irq_en_i);

endmodule
